dense_5_mac_engine: RTL and testbench



---
 rtl/dense_5_mac_engine.sv | 161 ++++++++++++++++
 tb/tb_dense_5_mac_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_5_mac_engine.sv
// dense_5_mac_engine: sequencer + MAC datapath for dense layer 5.
// Walks NUM_OUT neurons x NUM_IN inputs, reading one weight and one
// activation per cycle (both memories have 1-cycle registered read latency),
// accumulates zero-point-corrected products, requantizes to uint8 and emits
// one result per neuron.
// Optional feature: define DENSE5_RELU_EN to force negative scaled values
// to zero before the output zero point is added.
//
// Handshake: no backpressure. start is a 1-cycle request taken only in IDLE;
// w_en/a_en are read strobes whose data is consumed the following cycle;
// out_valid is a 1-cycle strobe, out_idx/out_data are valid with it and hold
// afterwards; done pulses once after the last neuron has been emitted.
module dense_5_mac_engine #(
  parameter int NUM_IN   = 169,
  parameter int NUM_OUT  = 3,
  parameter int W_ADDR_W = 10,
  parameter int A_ADDR_W = 8,
  parameter int IDX_W    = 2,
  parameter int ACC_W    = 32,
  parameter int IN_ZERO  = 1,
  parameter int W_ZERO   = 0,
  parameter int OUT_ZERO = -1,
  parameter int Q_MULT   = 1,
  parameter int Q_SHIFT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                w_en,
  output logic [W_ADDR_W-1:0] w_addr,
  input  logic [7:0]          w_data,
  output logic                a_en,
  output logic [A_ADDR_W-1:0] a_addr,
  input  logic [7:0]          a_data,
  output logic                out_valid,
  output logic [IDX_W-1:0]    out_idx,
  output logic [7:0]          out_data,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_LAST, S_SCALE, S_EMIT, S_DONE
  } state_t;

  localparam logic [A_ADDR_W-1:0] I_LAST = A_ADDR_W'(NUM_IN - 1);
  localparam logic [IDX_W-1:0]    O_LAST = IDX_W'(NUM_OUT - 1);
  localparam logic signed [8:0]   IZ9    = 9'(IN_ZERO);
  localparam logic signed [8:0]   WZ9    = 9'(W_ZERO);
  localparam logic signed [63:0]  QM64   = 64'(Q_MULT);
  localparam logic signed [63:0]  OZ64   = 64'(OUT_ZERO);
  // Half-LSB rounding constant; collapses to zero when Q_SHIFT is 0.
  localparam logic signed [63:0]  RND    = (64'sd1 <<< Q_SHIFT) >>> 1;

  state_t                     state, state_nx;
  logic [A_ADDR_W-1:0]        i_q;
  logic [W_ADDR_W-1:0]        wa_q;
  logic [IDX_W-1:0]           o_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [7:0]                 res_q;
  logic [IDX_W-1:0]           idx_q;

  logic signed [8:0]          a_op, w_op;
  logic signed [17:0]         prod;
  logic signed [63:0]         p_s, r_s, v_s;
  logic [7:0]                 clamp_v;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: if (i_q == I_LAST) state_nx = S_LAST;
      S_LAST:  state_nx = S_SCALE;
      S_SCALE: state_nx = S_EMIT;
      S_EMIT:  state_nx = (o_q == O_LAST) ? S_DONE : S_ISSUE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign w_en      = (state == S_ISSUE);
  assign a_en      = (state == S_ISSUE);
  assign out_valid = (state == S_EMIT);
  assign w_addr    = wa_q;
  assign a_addr    = i_q;
  assign out_idx   = idx_q;
  assign out_data  = res_q;
  assign dbg_state = state;

  // Product of the operands returned for the read issued last cycle.
  always_comb begin
    a_op = $signed({1'b0, a_data}) - IZ9;
    w_op = $signed({w_data[7], w_data}) - WZ9;
    prod = a_op * w_op;
  end

  // Requantize the finished sum: multiply, round, shift, offset, clamp.
  always_comb begin
    p_s = 64'(acc_q) * QM64;
    r_s = (p_s + RND) >>> Q_SHIFT;
`ifdef DENSE5_RELU_EN
    if (r_s < 64'sd0) r_s = 64'sd0;
`else
    r_s = r_s;
`endif
    v_s = r_s + OZ64;
    if (v_s < 64'sd0)        clamp_v = 8'd0;
    else if (v_s > 64'sd255) clamp_v = 8'd255;
    else                     clamp_v = v_s[7:0];
  end

  // Counters, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q   <= '0;
      wa_q  <= '0;
      o_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            i_q  <= '0;
            wa_q <= '0;
            o_q  <= '0;
          end
        end
        S_ISSUE: begin
          // First cycle of a neuron has no returned data yet: clear instead.
          if (i_q == '0) acc_q <= '0;
          else           acc_q <= acc_q + ACC_W'(prod);
          wa_q <= wa_q + W_ADDR_W'(1);
          if (i_q == I_LAST) i_q <= '0;
          else               i_q <= i_q + A_ADDR_W'(1);
        end
        S_LAST: acc_q <= acc_q + ACC_W'(prod);
        S_SCALE: begin
          res_q <= clamp_v;
          idx_q <= o_q;
        end
        S_EMIT: begin
          if (o_q != O_LAST) o_q <= o_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_5_mac_engine.sv
// Directed testbench for dense_5_mac_engine: default instance plus a second
// instance with Q_MULT=3, Q_SHIFT=2, both fed by the same memory contents.
module tb_dense_5_mac_engine;

  logic        clk = 1'b0;
  logic        rst, start;

  logic        busy, done, w_en, a_en, out_valid;
  logic [9:0]  w_addr;
  logic [7:0]  a_addr, w_data, a_data, out_data;
  logic [1:0]  out_idx;
  logic [2:0]  dbg_state;

  logic        busy2, done2, w_en2, a_en2, out_valid2;
  logic [9:0]  w_addr2;
  logic [7:0]  a_addr2, w_data2, a_data2, out_data2;
  logic [1:0]  out_idx2;
  logic [2:0]  dbg_state2;

  logic [7:0]  wrom [0:1023];
  logic [7:0]  abuf [0:255];

  int n_assert = 0;
  int n_fail   = 0;

  int pcnt = 0;
  int base = 0;
  int rel;
  bit mon_on = 1'b0;
  int ov_cyc[$];
  int ov_idx[$];
  int ov_dat[$];
  int ov2_dat[$];
  int done_cyc[$];
  int waddr_q[$];
  int aaddr_q[$];
  int busy_first, busy_last, busy_cnt;

  dense_5_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .a_en(a_en), .a_addr(a_addr), .a_data(a_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .dbg_state(dbg_state)
  );

  dense_5_mac_engine #(.Q_MULT(3), .Q_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
    .w_en(w_en2), .w_addr(w_addr2), .w_data(w_data2),
    .a_en(a_en2), .a_addr(a_addr2), .a_data(a_data2),
    .out_valid(out_valid2), .out_idx(out_idx2), .out_data(out_data2),
    .dbg_state(dbg_state2)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  // Memory models: registered read, 1-cycle latency.
  always @(posedge clk) begin
    if (w_en)  w_data  <= wrom[w_addr];
    if (a_en)  a_data  <= abuf[a_addr];
    if (w_en2) w_data2 <= wrom[w_addr2];
    if (a_en2) a_data2 <= abuf[a_addr2];
  end

  // Event recorder, sampled mid-cycle; rel counts cycles from the start pulse.
  always @(negedge clk) begin
    if (mon_on) begin
      rel = pcnt - base;
      if (out_valid) begin
        ov_cyc.push_back(rel);
        ov_idx.push_back(int'(out_idx));
        ov_dat.push_back(int'(out_data));
      end
      if (out_valid2) ov2_dat.push_back(int'(out_data2));
      if (done) done_cyc.push_back(rel);
      if (busy) begin
        if (busy_cnt == 0) busy_first = rel;
        busy_last = rel;
        busy_cnt++;
      end
      if (w_en) waddr_q.push_back(int'(w_addr));
      if (a_en) aaddr_q.push_back(int'(a_addr));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    ov_cyc.delete(); ov_idx.delete(); ov_dat.delete(); ov2_dat.delete();
    done_cyc.delete(); waddr_q.delete(); aaddr_q.delete();
    busy_first = -1; busy_last = -1; busy_cnt = 0;
  endtask

  task automatic fill(input int w_n0, input int w_n1, input int w_n2, input int act);
    for (int k = 0; k < 1024; k++) wrom[k] = 8'h00;
    for (int k = 0; k < 256; k++)  abuf[k] = 8'h00;
    for (int k = 0; k < 169; k++) begin
      wrom[k]       = 8'(w_n0);
      wrom[k + 169] = 8'(w_n1);
      wrom[k + 338] = 8'(w_n2);
      abuf[k]       = 8'(act);
    end
  endtask

  // Pulse start (cycle 0), optionally pulse again during cycle extra_at,
  // then wait for done with a bounded cycle budget.
  task automatic run_layer(input int extra_at);
    clear_mon();
    @(posedge clk); #1;
    start  = 1'b1;
    base   = pcnt;
    mon_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (extra_at > 0) begin
      while (pcnt < base + extra_at) begin
        @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    while (done_cyc.size() == 0 && (pcnt - base) < 700) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    mon_on = 1'b0;
    chk("done_within_budget", int'(done_cyc.size() > 0), 1);
  endtask

  task automatic check_layer(input string tag, input int e0, input int e1, input int e2,
                             input int f0, input int f1, input int f2);
    int exp_d[3];
    int exp_f[3];
    int bad;
    exp_d = '{e0, e1, e2};
    exp_f = '{f0, f1, f2};
    chk({tag, ":ov_count"}, ov_cyc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s:ov_cyc[%0d]", tag, k), (k < ov_cyc.size()) ? ov_cyc[k] : -1, 172 + 172 * k);
      chk($sformatf("%s:ov_idx[%0d]", tag, k), (k < ov_idx.size()) ? ov_idx[k] : -1, k);
      chk($sformatf("%s:ov_dat[%0d]", tag, k), (k < ov_dat.size()) ? ov_dat[k] : -1, exp_d[k]);
      chk($sformatf("%s:q_ov_dat[%0d]", tag, k), (k < ov2_dat.size()) ? ov2_dat[k] : -1, exp_f[k]);
    end
    chk({tag, ":q_ov_count"}, ov2_dat.size(), 3);
    chk({tag, ":done_count"}, done_cyc.size(), 1);
    chk({tag, ":done_cyc"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, 517);
    chk({tag, ":busy_first"}, busy_first, 1);
    chk({tag, ":busy_last"}, busy_last, 517);
    chk({tag, ":busy_cnt"}, busy_cnt, 517);
    chk({tag, ":waddr_count"}, waddr_q.size(), 507);
    bad = 0;
    for (int k = 0; k < waddr_q.size(); k++) if (waddr_q[k] != k) bad++;
    chk({tag, ":waddr_seq_errors"}, bad, 0);
    chk({tag, ":aaddr_count"}, aaddr_q.size(), 507);
    bad = 0;
    for (int k = 0; k < aaddr_q.size(); k++) if (aaddr_q[k] != (k % 169)) bad++;
    chk({tag, ":aaddr_seq_errors"}, bad, 0);
    chk({tag, ":out_data_hold"}, int'(out_data), e2);
    chk({tag, ":out_idx_hold"}, int'(out_idx), 2);
    chk({tag, ":state_idle"}, int'(dbg_state), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(1, 1, 1, 2);
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset values.
    chk("rst:busy", int'(busy), 0);
    chk("rst:done", int'(done), 0);
    chk("rst:w_en", int'(w_en), 0);
    chk("rst:a_en", int'(a_en), 0);
    chk("rst:out_valid", int'(out_valid), 0);
    chk("rst:w_addr", int'(w_addr), 0);
    chk("rst:a_addr", int'(a_addr), 0);
    chk("rst:out_idx", int'(out_idx), 0);
    chk("rst:out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Weights 1, activations 2, extra start at cycle 50 must be ignored.
    fill(1, 1, 1, 2);
    run_layer(50);
    check_layer("basic", 168, 168, 168, 126, 126, 126);

    // Weights 127, activations 255: saturates high.
    fill(127, 127, 127, 255);
    run_layer(0);
    check_layer("sat", 255, 255, 255, 255, 255, 255);

    // Neuron 1 negative: clamps to 0 (also 0 with the ReLU option).
    fill(1, -1, 1, 2);
    run_layer(0);
    check_layer("neg", 168, 0, 168, 126, 0, 126);

    // Reset asserted during cycle 200.
    fill(1, 1, 1, 2);
    clear_mon();
    @(posedge clk); #1;
    start  = 1'b1;
    base   = pcnt;
    mon_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (pcnt < base + 200) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst:busy", int'(busy), 0);
    chk("midrst:w_en", int'(w_en), 0);
    chk("midrst:a_en", int'(a_en), 0);
    chk("midrst:out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    mon_on = 1'b0;
    chk("midrst:ov_count", ov_cyc.size(), 1);
    chk("midrst:done_count", done_cyc.size(), 0);
    chk("midrst:busy_last", busy_last, 200);
    run_layer(0);
    check_layer("after_rst", 168, 168, 168, 126, 126, 126);

    // start coincident with rst: reset wins.
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start:busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("rst_start:busy_later", int'(busy), 0);
    chk("rst_start:w_en", int'(w_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
